// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the synchronous instruction memory and
// holds the IF/ID register, with source-register and load/SAC pre-decode.
//
// Parameters:
//   PC_WIDTH  - PC and branch-target width (byte address)
//   RESET_PC  - PC value loaded on reset
//   LOAD_OP   - opcode flagged as a memory read
//   SAC_OP    - second opcode flagged as a memory read
//   HALT_OP   - opcode that stops fetch
//
// Ports:
//   clk, rst       - clock; asynchronous active-high reset
//   stall_pc       - hazard-unit PC stall
//   stall_mem      - hazard-unit full-pipeline stall
//   hazard         - load-use hazard, freezes IF/ID
//   flush          - taken branch/jump in EX
//   branch_target  - redirect PC, valid with flush
//   imem_addr      - instruction-memory read address (combinational)
//   imem_rdata     - instruction returned one cycle after imem_addr
//   pc_if_id       - PC of the IF/ID instruction
//   instr_if_id    - IF/ID instruction, zero when invalid
//   valid_if_id    - IF/ID holds a real instruction
//   src_reg1_if_id - rs1 field of instr_if_id
//   src_reg2_if_id - rs2 field of instr_if_id
//   memread_if_id  - valid load or SAC in IF/ID
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetched - wrapping count of valid IF/ID loads
//   perf_stall   - wrapping count of RUN cycles with a hold

module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]          LOAD_OP  = 5'h02,
  parameter logic [4:0]          SAC_OP   = 5'h03,
  parameter logic [4:0]          HALT_OP  = 5'h1F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_pc,
  input  logic                stall_mem,
  input  logic                hazard,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] pc_if_id,
  output logic [31:0]         instr_if_id,
  output logic                valid_if_id,
  output logic [4:0]          src_reg1_if_id,
  output logic [4:0]          src_reg2_if_id,
  output logic                memread_if_id
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_id_q, pc_id_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;

  logic       hold;
  logic       load_en;
  logic [4:0] rdata_op;
  logic [4:0] id_op;

  assign hold     = stall_pc | stall_mem | hazard;
  assign rdata_op = imem_rdata[31:27];
  assign id_op    = instr_q[31:27];

  // A real instruction enters IF/ID only in RUN with no flush or hold.
  assign load_en  = (state_q == RUN) & ~hold & ~flush;

  // PC select; flush outranks every hold so the target is never frozen.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = branch_target;
    end else if (hold || state_q != RUN) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_WIDTH'(4);
    end
  end

  // IF/ID next state.
  always_comb begin
    pc_id_d = pc_id_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (hold) begin
      pc_id_d = pc_id_q;
    end else if (state_q == RUN) begin
      pc_id_d = pc_q;
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end else begin
      instr_d = '0;
      valid_d = 1'b0;
    end
  end

  // Fetch control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: begin
        // First cycle after reset: memory data is not yet valid.
        if (!hold) state_d = RUN;
      end
      RUN: begin
        // The halt word itself still enters IF/ID and goes downstream.
        if (load_en && rdata_op == HALT_OP) state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pc_id_q <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_id_q <= pc_id_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Reset gates the address so memory sees RESET_PC even if flush is high.
  assign imem_addr      = rst ? RESET_PC : pc_d;

  assign pc_if_id       = pc_id_q;
  assign instr_if_id    = instr_q;
  assign valid_if_id    = valid_q;
  assign src_reg1_if_id = instr_q[21:17];
  assign src_reg2_if_id = instr_q[16:12];
  assign memread_if_id  = valid_q &
                          ((id_op == LOAD_OP) | (id_op == SAC_OP));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (load_en) perf_fetched_d = perf_fetched_q + 32'd1;
    if (hold && state_q == RUN) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector bench for fetch_stage.
// Memory returns addr>>2 except for a load word and a halt word.

module tb_fetch_stage;

  localparam logic [31:0] LOADW = {5'h02, 5'd1, 5'd5, 5'd9, 12'h0};
  localparam logic [31:0] HALTW = {5'h1F, 27'h0};

  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        stall_mem;
  logic        hazard;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if_id;
  logic [31:0] instr_if_id;
  logic        valid_if_id;
  logic [4:0]  src_reg1_if_id;
  logic [4:0]  src_reg2_if_id;
  logic        memread_if_id;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_chk;
  int n_pass;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pc       (stall_pc),
    .stall_mem      (stall_mem),
    .hazard         (hazard),
    .flush          (flush),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_if_id       (pc_if_id),
    .instr_if_id    (instr_if_id),
    .valid_if_id    (valid_if_id),
    .src_reg1_if_id (src_reg1_if_id),
    .src_reg2_if_id (src_reg2_if_id),
    .memread_if_id  (memread_if_id)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h18) return LOADW;
    if (a == 32'h20) return HALTW;
    return a >> 2;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        sp;
    logic        sm;
    logic        hz;
    logic        fl;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        mr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic sp, input logic sm,
                              input logic hz, input logic fl,
                              input logic [31:0] tgt,
                              input logic [31:0] addr,
                              input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic mr);
    vec_t r;
    r.sp = sp; r.sm = sm; r.hz = hz; r.fl = fl; r.tgt = tgt;
    r.addr = addr; r.v = v; r.pc = pc; r.ins = ins; r.mr = mr;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    stall_pc = 0; stall_mem = 0; hazard = 0; flush = 0;
    branch_target = '0;

    //          sp sm hz fl tgt     addr    v pc      ins     mr
    vt.push_back(mk(0,0,0,0,0,      32'h00, 0,0,      0,      0)); // boot
    vt.push_back(mk(0,0,0,0,0,      32'h04, 1,32'h00, 32'h0,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h08, 1,32'h04, 32'h1,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h0C, 1,32'h08, 32'h2,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h10, 1,32'h0C, 32'h3,  0));
    vt.push_back(mk(1,0,0,0,0,      32'h10, 1,32'h0C, 32'h3,  0)); // hold
    vt.push_back(mk(1,0,0,0,0,      32'h10, 1,32'h0C, 32'h3,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h14, 1,32'h10, 32'h4,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h18, 1,32'h14, 32'h5,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h1C, 1,32'h18, LOADW,  1)); // load
    vt.push_back(mk(0,0,0,0,0,      32'h20, 1,32'h1C, 32'h7,  0));
    vt.push_back(mk(0,0,0,0,0,      32'h24, 1,32'h20, HALTW,  0)); // halt
    vt.push_back(mk(0,0,0,0,0,      32'h24, 0,0,      0,      0));
    vt.push_back(mk(0,0,0,0,0,      32'h24, 0,0,      0,      0));
    vt.push_back(mk(0,0,0,1,32'h40, 32'h40, 0,0,      0,      0)); // resume
    vt.push_back(mk(0,0,0,0,0,      32'h44, 1,32'h40, 32'h10, 0));
    vt.push_back(mk(0,0,0,0,0,      32'h48, 1,32'h44, 32'h11, 0));
    vt.push_back(mk(0,0,1,1,32'h100,32'h100,0,0,      0,      0)); // fl+hz
    vt.push_back(mk(0,0,0,0,0,      32'h104,1,32'h100,32'h40, 0));
    vt.push_back(mk(0,0,0,0,0,      32'h108,1,32'h104,32'h41, 0));
    vt.push_back(mk(0,0,1,0,0,      32'h108,1,32'h104,32'h41, 0));
    vt.push_back(mk(0,1,0,0,0,      32'h108,1,32'h104,32'h41, 0));
    vt.push_back(mk(0,0,0,0,0,      32'h10C,1,32'h108,32'h42, 0));
    vt.push_back(mk(1,0,0,1,32'h200,32'h200,0,0,      0,      0)); // fl+sp
    vt.push_back(mk(0,0,0,0,0,      32'h204,1,32'h200,32'h80, 0));
    vt.push_back(mk(0,0,0,1,32'h80, 32'h80, 0,0,      0,      0));
    vt.push_back(mk(0,0,0,0,0,      32'h84, 1,32'h80, 32'h20, 0));

    #2;
    chk("rst_valid", 32'(valid_if_id), 32'h0);
    chk("rst_instr", instr_if_id, 32'h0);
    chk("rst_pc", pc_if_id, 32'h0);
    chk("rst_memread", 32'(memread_if_id), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      stall_pc = vt[i].sp;
      stall_mem = vt[i].sm;
      hazard = vt[i].hz;
      flush = vt[i].fl;
      branch_target = vt[i].tgt;
      #1;
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(valid_if_id), 32'(vt[i].v));
      if (vt[i].v)
        chk($sformatf("v%0d_pc", i), pc_if_id, vt[i].pc);
      chk($sformatf("v%0d_instr", i), instr_if_id, vt[i].ins);
      chk($sformatf("v%0d_memread", i), 32'(memread_if_id), 32'(vt[i].mr));
      chk($sformatf("v%0d_rs1", i), 32'(src_reg1_if_id),
          32'(vt[i].ins[21:17]));
      chk($sformatf("v%0d_rs2", i), 32'(src_reg2_if_id),
          32'(vt[i].ins[16:12]));
    end
    stall_pc = 0; stall_mem = 0; hazard = 0; flush = 0;

`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd16);
    chk("perf_stall", perf_stall, 32'd6);
`endif

    // Mid-cycle asynchronous reset during RUN at PC 0x80.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_if_id), 32'h0);
    chk("arst_instr", instr_if_id, 32'h0);
    chk("arst_pc", pc_if_id, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("arst_perf", perf_fetched, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reboot_bubble", 32'(valid_if_id), 32'h0);
    @(posedge clk);
    #1;
    chk("reboot_valid", 32'(valid_if_id), 32'h1);
    chk("reboot_pc", pc_if_id, 32'h0);
    @(posedge clk);
    #1;
    chk("reboot_pc4", pc_if_id, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
